// File: rtl/alu_seq.sv
// alu_seq: sequential ALU. ADD/SUB/CMP/logic ops take 1 cycle, LSH takes n+1, MUL takes WIDTH+1 (only when ALU_SEQ_MUL_EN is defined).
// ready is low only while iterating; a start seen while busy is dropped, and the outputs are never stalled.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       psrWrite,
  output logic [4:0]       psrWrEn
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_CMP = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_LSH = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, nextState;
  logic [2:0]       opReg;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] workNext;
  logic [CW-1:0]    cnt;
`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
`endif

  logic             accept;
  logic             goRun;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] immRes;
  logic [4:0]       immFlags;
  logic [4:0]       immEn;

  assign ready  = (state != RUN);
  assign done   = (state == DONE);
  assign accept = start && ready;

  // Flag bits: [0]C [1]L [2]F [3]Z [4]N; only enabled bits are ever set.
  always_comb begin
    sum      = {1'b0, srcA} + {1'b0, srcB};
    diff     = {1'b0, srcA} - {1'b0, srcB};
    immRes   = '0;
    immFlags = '0;
    immEn    = '0;
    goRun    = 1'b0;
    case (opcode)
      OP_ADD: begin
        immRes      = sum[WIDTH-1:0];
        immEn       = 5'b00101;
        immFlags[0] = sum[WIDTH];
        immFlags[2] = (srcA[WIDTH-1] == srcB[WIDTH-1]) && (sum[WIDTH-1] != srcA[WIDTH-1]);
      end
      OP_SUB: begin
        immRes      = diff[WIDTH-1:0];
        immEn       = 5'b00101;
        immFlags[0] = diff[WIDTH];
        immFlags[2] = (srcA[WIDTH-1] != srcB[WIDTH-1]) && (diff[WIDTH-1] != srcA[WIDTH-1]);
      end
      OP_CMP: begin
        immRes      = srcA;
        immEn       = 5'b11010;
        immFlags[1] = (srcA < srcB);
        immFlags[3] = (srcA == srcB);
        immFlags[4] = ($signed(srcA) < $signed(srcB));
      end
      OP_AND: immRes = srcA & srcB;
      OP_OR:  immRes = srcA | srcB;
      OP_XOR: immRes = srcA ^ srcB;
      OP_LSH: begin
        immRes = srcA;
        goRun  = |srcB[3:0];
      end
      OP_MUL: begin
`ifdef ALU_SEQ_MUL_EN
        goRun  = 1'b1;
`else
        immRes = '0;
`endif
      end
      default: immRes = '0;
    endcase
  end

  always_comb begin
    workNext = work << 1;
`ifdef ALU_SEQ_MUL_EN
    if (opReg == OP_MUL) workNext = work + (mplier[0] ? mcand : '0);
`endif
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE, DONE: begin
        if (accept) nextState = goRun ? RUN : DONE;
        else        nextState = IDLE;
      end
      RUN:     if (cnt == CW'(1)) nextState = DONE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= nextState;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      opReg    <= '0;
      work     <= '0;
      cnt      <= '0;
      result   <= '0;
      psrWrite <= '0;
      psrWrEn  <= '0;
`ifdef ALU_SEQ_MUL_EN
      mcand    <= '0;
      mplier   <= '0;
`endif
    end else if (accept) begin
      opReg <= opcode;
      if (goRun) begin
        psrWrite <= '0;
        psrWrEn  <= '0;
        work     <= srcA;
        cnt      <= CW'(srcB[3:0]);
`ifdef ALU_SEQ_MUL_EN
        if (opcode == OP_MUL) begin
          work   <= '0;
          cnt    <= CW'(WIDTH);
          mcand  <= srcA;
          mplier <= srcB;
        end
`endif
      end else begin
        result   <= immRes;
        psrWrite <= immFlags;
        psrWrEn  <= immEn;
      end
    end else if (state == RUN) begin
      work <= workNext;
      cnt  <= cnt - CW'(1);
`ifdef ALU_SEQ_MUL_EN
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
`endif
      // The final iteration's value goes straight into result as DONE is entered.
      if (cnt == CW'(1)) begin
        result <= workNext;
`ifdef ALU_SEQ_MUL_EN
        if (opReg == OP_MUL) begin
          psrWrEn  <= 5'b01000;
          psrWrite <= {1'b0, ~|workNext, 3'b000};
        end
`endif
      end
    end else begin
      psrWrite <= '0;
      psrWrEn  <= '0;
    end
  end

endmodule
